// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scanner.
// Holds the default digit count, the all-dark segment pattern and the
// 16-entry active-low hex pattern table ({g,f,e,d,c,b,a}).
package seg_pkg;
    localparam int DEF_DIGITS = 8;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment decoder.
// Ports: hex - 4-bit value in; seg - {g,f,e,d,c,b,a}, active-low.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb seg = SEG_PAT[hex];
endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment display scanner.
// Ports: clk - rising-edge clock; rst - synchronous active-low reset;
//        en - scan enable (low = dark, scan paused); tick - async divided clock,
//        each rising edge advances one digit; data - hex nibble per digit;
//        blank - per-digit force-off; dp - per-digit decimal point request;
//        an - active-low digit selects; seg - active-low {g,f,e,d,c,b,a};
//        dp_n - active-low decimal point.
// Option: define SEG_SCAN_LEADING_ZERO_BLANK_EN to auto-blank leading zeros.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  tick,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n
);
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    logic s1, s2, s3, adv, wrap, dark, dp_n_d;
    logic [IW-1:0] idx, idx_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [DIGITS-1:0] blank_q, blank_d, dp_q, dp_d, lz, an_d;
    logic [3:0] nib;
    logic [6:0] hex_seg, seg_d;
    // Outputs are computed from the next idx and next frame copies so that the
    // registered display always matches the digit selected on the same edge.
    always_comb begin
        adv = en & s2 & ~s3;
        wrap = adv && idx == LAST;
        idx_d = adv ? (wrap ? '0 : idx + 1'b1) : idx;
        data_d = wrap ? data : data_q;
        blank_d = wrap ? blank : blank_q;
        dp_d = wrap ? dp : dp_q;
        nib = 4'(data_d >> {idx_d, 2'b00});
        lz = '0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < DIGITS; i++)
            lz[i] = (data_d >> (4 * i)) == '0;
`endif
        dark = !en || blank_d[idx_d] || lz[idx_d];
        an_d = dark ? '1 : ~(DIGITS'(1) << idx_d);
        seg_d = dark ? SEG_OFF : hex_seg;
        dp_n_d = dark | ~dp_d[idx_d];
    end
    hex7seg u_hex (.hex(nib), .seg(hex_seg));
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            idx <= '0;
            data_q <= '0;
            blank_q <= '1;
            dp_q <= '0;
            an <= '1;
            seg <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            s1 <= tick;
            s2 <= s1;
            s3 <= s2;
            idx <= idx_d;
            data_q <= data_d;
            blank_q <= blank_d;
            dp_q <= dp_d;
            an <= an_d;
            seg <= seg_d;
            dp_n <= dp_n_d;
        end
    end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed seven-segment digits. Legal values are 2..8.
REQ-002 clk  input  1  system clock. All logic is clocked on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 en  input  1  scan enable; when low, the display is dark and scanning pauses.
REQ-005 tick  input  1  divided-clock level from the clock divider, asynchronous to this block's logic; each rising edge advances the scan by one digit.
REQ-006 data  input  4*DIGITS  hex nibbles; nibble i drives digit i.
REQ-007 blank  input  DIGITS  per-digit force-off mask; 1 means the digit stays dark.
REQ-008 dp  input  DIGITS  per-digit decimal-point request; 1 means the point is lit.
REQ-009 an  output  DIGITS  digit selects, active-low, one-hot-low or all ones.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp_n  output  1  decimal point, active-low.

Function
REQ-012 tick SHALL pass through a 2-flop synchronizer (s1, s2) and a delay flop (s3); the advance pulse is s2 & ~s3.
REQ-013 On an advance pulse with en=1, the digit index idx SHALL increment by one, wrapping from DIGITS-1 to 0.
REQ-014 an, seg and dp_n SHALL be registered and SHALL update on the same edge as idx, reflecting the new idx.
- Latency: tick high at clk edge k gives new outputs after edge k+2.
REQ-015 When idx wraps to 0, data_q SHALL load data, blank_q SHALL load blank, and dp_q SHALL load dp, all on that same edge.
- Display decoding uses only these frame-latched copies, so a frame never tears.
REQ-016 Drive rule for the selected digit:
- an[idx]=0 and all other an bits are 1.
- seg = hex decode of data_q[4*idx+3:4*idx].
- dp_n = ~dp_q[idx].
REQ-017 If blank_q[idx]=1, the outputs SHALL be an all ones, seg=7'h7F and dp_n=1; idx still advances normally.
REQ-018 Hex decode values:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-019 With en=0, the outputs SHALL be an all ones, seg=7F and dp_n=1.
- idx and the latched copies hold.
- Advance pulses are ignored.
- The synchronizer keeps running.
REQ-020 On the edge where en rises, the outputs SHALL redisplay the current idx; advancing resumes on the next pulse.
REQ-021 An advance pulse coinciding with en falling SHALL be dropped; the en=0 behaviour takes priority.
REQ-022 A tick pulse shorter than 2 clk periods is not guaranteed to be detected. Each detected edge advances idx by exactly one, with no double steps.

Reset
REQ-023 With rst=0 at a clk edge, the block SHALL reset as follows:
- s1=s2=s3=0 and idx=0.
- data_q=0, blank_q=all ones, dp_q=0.
- an=all ones, seg=7F, dp_n=1.
REQ-024 A reset asserted mid-frame SHALL take effect on that edge. After release, the first advance pulse goes to idx=1; digit 0 is only loaded at the next wrap.

Configuration
REQ-025 Macro SEG_SCAN_LEADING_ZERO_BLANK_EN:
- Defined: digit i (i>=1) SHALL also be blanked when data_q nibbles i..DIGITS-1 are all zero. Digit 0 is never auto-blanked. This combines with blank_q by OR.
- Undefined: only blank_q blanks, and zeros display as "0".

Structure
REQ-026 Package seg_pkg SHALL hold the 16-entry segment pattern constants, SEG_OFF=7'h7F and the default DIGITS.
REQ-027 Hex decoding SHALL live in the combinational sub-module hex7seg (4-bit in, 7-bit active-low out). seg_scan registers its output.

Verification
REQ-028 Reset: hold rst=0 for 3 clks with tick toggling -> an=FF, seg=7F, dp_n=1, idx=0.
REQ-029 Scan order: data=32'h1234ABCD, blank=0, dp=8'h01, en=1, tick square wave of 20 clks.
- First pass shows all digits dark, from the reset-state blank_q.
- After the wrap, an cycles FE,FD,...,7F with seg D=21, C=46, B=03, A=08, 4=19, 3=30, 2=24, 1=79.
- dp_n=0 only while an=FE.
REQ-030 Frame latch: change data to 32'h0 while idx=3 -> digits 3..7 still show the old nibbles. After the wrap to idx=0, all digits show 40.
REQ-031 Enable: drop en for 5 ticks while idx=5 -> an=FF and idx stays 5. After en rises, an=DF immediately, then BF after the next tick.
REQ-032 Blank mask: blank=8'hF0 -> an is FF during idx 4..7 while scanning continues, and digits 0..3 are displayed normally.
REQ-033 Macro defined with data=32'h000000F0 -> only an=FE (seg 40) and an=FD (seg 0E) light. Macro undefined with the same data -> digits 2..7 show 40.
